// File: rtl/p6_fetch_unit.sv
// p6_fetch_unit
//   Instruction fetch stage sitting directly in front of the CPU. It owns the
//   program counter, issues one RAM read per instruction, waits out the RAM
//   read latency, latches the returned word into the instruction register and
//   offers it to the CPU with a valid/ack handshake. On acknowledge the next
//   PC is either pc+1 (wrapping modulo 2^ADDR_W) or the branch target the CPU
//   reports alongside the ack. Fetching stops for good once an acknowledged
//   instruction carries the HALT opcode in its top three bits.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-low; clears all state immediately
//   start      : level request to begin fetching, only looked at in IDLE
//   mem_addr   : RAM read address, always equal to pc
//   mem_rd     : RAM read strobe, high for exactly one cycle per fetch
//   mem_data   : RAM read data, valid MEM_LAT cycles after mem_rd
//   ir         : latched instruction
//   ir_valid   : ir holds an instruction the CPU has not consumed yet
//   ir_ack     : CPU consumes ir this cycle (only looked at while holding)
//   br_taken   : qualifies ir_ack; next pc comes from br_target
//   br_target  : branch destination, used verbatim
//   pc         : current PC (address of the instruction in ir while holding)
//   halted     : a HALT instruction was consumed; fetching has stopped

module p6_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MEM_LAT  = 1,
  parameter logic [2:0]        HALT_OPC = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ack,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  // MEM_LAT is limited to 1..4, so three bits hold every count value.
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic                ir_valid_q;
  logic                mem_rd_q;
  logic                halted_q;
  logic [2:0]          lat_cnt;

  // Sequential successor wraps silently at the top of the address space.
  function automatic logic [ADDR_W-1:0] next_pc(input logic              taken,
                                                input logic [ADDR_W-1:0] target,
                                                input logic [ADDR_W-1:0] cur);
    return taken ? target : cur + 1'b1;
  endfunction

  function automatic logic is_halt(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: 3] == HALT_OPC;
  endfunction

  // mem_rd, ir_valid and halted are registered: each is set on the edge
  // that enters the state in which it must be high, so they line up with
  // the state register without any decode after the flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      mem_rd_q   <= 1'b0;
      halted_q   <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_REQ;
            mem_rd_q <= 1'b1;
          end
        end

        S_REQ: begin
          lat_cnt <= '0;
          state   <= S_WAIT;
        end

        // lat_cnt is 0 in the first WAIT cycle; the read data is on the bus
        // during the cycle in which lat_cnt reaches MEM_LAT-1.
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            ir_q       <= mem_data;
            ir_valid_q <= 1'b1;
            state      <= S_HOLD;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        // A HALT instruction is still handed over and must be acked; the ack
        // moves pc past it before fetching stops.
        S_HOLD: begin
          if (ir_ack) begin
            ir_valid_q <= 1'b0;
            pc_q       <= next_pc(br_taken, br_target, pc_q);
            if (is_halt(ir_q)) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state    <= S_REQ;
              mem_rd_q <= 1'b1;
            end
          end
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr = pc_q;
  assign mem_rd   = mem_rd_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc       = pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_p6_fetch_unit.sv
// Bench for p6_fetch_unit: one instance with MEM_LAT=1 for the main fetch,
// handshake, branch, wrap and HALT behaviour, and one with MEM_LAT=3 for
// latency and reset-during-read behaviour. Each instance has its own RAM
// model that drives real data only in the cycle it is due and 16'hDEAD
// otherwise.

module tb_p6_fetch_unit;

  logic        clk;
  // MEM_LAT = 1 instance
  logic        reset, start, ir_ack, br_taken;
  logic [7:0]  br_target, mem_addr, pc;
  logic        mem_rd, ir_valid, halted;
  logic [15:0] mem_data, ir;
  // MEM_LAT = 3 instance
  logic        reset3, start3, ir_ack3, br_taken3;
  logic [7:0]  br_target3, mem_addr3, pc3;
  logic        mem_rd3, ir_valid3, halted3;
  logic [15:0] mem_data3, ir3;

  logic [15:0] ram1 [256];
  logic [15:0] ram3 [256];
  logic [15:0] d3a, d3b, d3c;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt;
  int n_wait;
  int bad;
  logic [15:0] ir_hold;
  logic [7:0]  pc_hold;

  typedef struct {
    logic        start;
    logic        ack;
    logic        br;
    logic [7:0]  tgt;
    logic        exp_rd;
    logic [7:0]  exp_pc;
    logic        exp_iv;
    logic [15:0] exp_ir;
    logic        exp_halt;
  } vec_t;

  vec_t tbl [13];

  p6_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .MEM_LAT(1),
                  .HALT_OPC(3'b111)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid),
    .ir_ack(ir_ack), .br_taken(br_taken), .br_target(br_target), .pc(pc),
    .halted(halted));

  p6_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .MEM_LAT(3),
                  .HALT_OPC(3'b111)) dut3 (
    .clk(clk), .reset(reset3), .start(start3), .mem_addr(mem_addr3),
    .mem_rd(mem_rd3), .mem_data(mem_data3), .ir(ir3), .ir_valid(ir_valid3),
    .ir_ack(ir_ack3), .br_taken(br_taken3), .br_target(br_target3), .pc(pc3),
    .halted(halted3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: data is valid exactly MEM_LAT cycles after the strobe.
  always @(posedge clk) mem_data <= mem_rd ? ram1[mem_addr] : 16'hDEAD;

  always @(posedge clk) begin
    d3a <= mem_rd3 ? ram3[mem_addr3] : 16'hDEAD;
    d3b <= d3a;
    d3c <= d3b;
  end
  assign mem_data3 = d3c;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (mem_rd) rd_cnt++;
  endtask

  task automatic wait_iv(input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      cyc();
      if (ir_valid) begin
        n = i;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_ir_valid: got no ir_valid within %0d cycles", max_cyc);
  endtask

  task automatic wait_iv3(input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      cyc();
      if (ir_valid3) begin
        n = i;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_ir_valid3: got no ir_valid within %0d cycles", max_cyc);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ir_ack = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    reset3 = 1'b0; start3 = 1'b0; ir_ack3 = 1'b0; br_taken3 = 1'b0; br_target3 = 8'h00;
    rd_cnt = 0;

    for (int i = 0; i < 256; i++) begin
      ram1[i] = 16'h0100 + 16'(i);
      ram3[i] = 16'h0200 + 16'(i);
    end
    ram1[8'h00] = 16'h1111;
    ram1[8'h01] = 16'h2222;
    ram1[8'h02] = 16'h3333;
    ram1[8'h03] = 16'hE000;
    ram1[8'h05] = 16'h5555;
    ram1[8'h40] = 16'h4040;
    ram1[8'hFF] = 16'h0FF0;
    ram3[8'h00] = 16'hA0A0;
    ram3[8'h01] = 16'hB1B1;

    // start, ack, br, tgt | rd, pc, iv, ir, halted  (state after each edge)
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 16'h1111, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 16'h1111, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h01, 1'b0, 16'h1111, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 16'h2222, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 16'h2222, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 16'h2222, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 16'h3333, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 16'h3333, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 16'h3333, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 16'hE000, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0, 16'hE000, 1'b1};

    // Reset state
    repeat (3) cyc();
    chk("reset_state", {mem_rd, mem_addr, pc, ir_valid, ir, halted}, 64'h0);
    reset = 1'b1;

    // Streaming fetch with ack held high, ending on the HALT instruction
    for (int k = 0; k < 13; k++) begin
      start = tbl[k].start; ir_ack = tbl[k].ack;
      br_taken = tbl[k].br; br_target = tbl[k].tgt;
      cyc();
      chk($sformatf("vec%0d", k + 1),
          {mem_rd, mem_addr, pc, ir_valid, ir, halted},
          {tbl[k].exp_rd, tbl[k].exp_pc, tbl[k].exp_pc, tbl[k].exp_iv,
           tbl[k].exp_ir, tbl[k].exp_halt});
    end

    // Halted: start, ack and branch requests are all ignored
    start = 1'b1; ir_ack = 1'b1; br_taken = 1'b1; br_target = 8'h99;
    rd_cnt = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (!halted || ir_valid || pc != 8'h04) bad++;
    end
    chk("halt_no_reads", 64'(rd_cnt), 64'd0);
    chk("halt_stable", 64'(bad), 64'd0);

    // Async reset out of HALT, then hold an instruction unacked
    @(negedge clk);
    reset = 1'b0; start = 1'b0; ir_ack = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    #1;
    chk("reset_from_halt", {mem_rd, pc, ir_valid, ir, halted}, 64'h0);
    cyc();
    reset = 1'b1;
    rd_cnt = 0;
    start = 1'b1;
    wait_iv(20, n_wait);
    chk("first_fetch_latency", 64'(n_wait), 64'd3);
    chk("hold_contents", {ir, pc}, {16'h1111, 8'h00});
    ir_hold = ir; pc_hold = pc;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ir != ir_hold || pc != pc_hold || !ir_valid) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    chk("hold_one_read", 64'(rd_cnt), 64'd1);

    // Branch to 5, then from 5 branch to 8'h40
    ir_ack = 1'b1; br_taken = 1'b1; br_target = 8'h05;
    cyc();
    chk("br_to_5", {mem_rd, mem_addr, pc, ir_valid}, {1'b1, 8'h05, 8'h05, 1'b0});
    ir_ack = 1'b0; br_taken = 1'b0;
    wait_iv(20, n_wait);
    chk("fetch_at_5", {ir, pc}, {16'h5555, 8'h05});
    br_taken = 1'b1; br_target = 8'h77;
    cyc();
    chk("br_without_ack", {mem_rd, pc, ir_valid}, {1'b0, 8'h05, 1'b1});
    ir_ack = 1'b1; br_taken = 1'b1; br_target = 8'h40;
    cyc();
    chk("br_to_40", {mem_rd, mem_addr, pc, ir_valid}, {1'b1, 8'h40, 8'h40, 1'b0});
    ir_ack = 1'b0; br_taken = 1'b0;
    wait_iv(20, n_wait);
    chk("fetch_at_40", {ir, pc}, {16'h4040, 8'h40});

    // Branch to the current pc re-fetches the same word
    ir_ack = 1'b1; br_taken = 1'b1; br_target = 8'h40;
    cyc();
    chk("refetch_req", {mem_rd, mem_addr, pc}, {1'b1, 8'h40, 8'h40});
    ir_ack = 1'b0; br_taken = 1'b0;
    wait_iv(20, n_wait);
    chk("refetch_data", {ir, pc}, {16'h4040, 8'h40});

    // Sequential step from 8'hFF wraps to 8'h00
    ir_ack = 1'b1; br_taken = 1'b1; br_target = 8'hFF;
    cyc();
    ir_ack = 1'b0; br_taken = 1'b0;
    wait_iv(20, n_wait);
    chk("fetch_at_ff", {ir, pc}, {16'h0FF0, 8'hFF});
    ir_ack = 1'b1;
    cyc();
    chk("wrap_req", {mem_rd, mem_addr, pc}, {1'b1, 8'h00, 8'h00});
    ir_ack = 1'b0;
    wait_iv(20, n_wait);
    chk("wrap_data", {ir, pc}, {16'h1111, 8'h00});

    // MEM_LAT = 3: latency, then reset in the middle of a read
    start = 1'b0;
    reset3 = 1'b1;
    start3 = 1'b1;
    wait_iv3(20, n_wait);
    chk("lat3_latency", 64'(n_wait), 64'd5);
    chk("lat3_data", {ir3, pc3}, {16'hA0A0, 8'h00});
    ir_ack3 = 1'b1;
    cyc();
    ir_ack3 = 1'b0;
    cyc();
    chk("lat3_in_wait", {mem_rd3, pc3, ir_valid3}, {1'b0, 8'h01, 1'b0});
    reset3 = 1'b0;
    #1;
    chk("lat3_async_reset", {mem_rd3, mem_addr3, pc3, ir_valid3, ir3, halted3}, 64'h0);
    cyc();
    reset3 = 1'b1;
    start3 = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ir3 != 16'h0000 || ir_valid3 || mem_rd3) bad++;
    end
    chk("lat3_late_data_dropped", 64'(bad), 64'd0);
    start3 = 1'b1;
    cyc();
    chk("lat3_restart_req", {mem_rd3, mem_addr3, pc3}, {1'b1, 8'h00, 8'h00});
    wait_iv3(20, n_wait);
    chk("lat3_restart_data", {ir3, pc3}, {16'hA0A0, 8'h00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
